// File: rtl/txdata_pkg.sv
// txdata_pkg: shared types and constants for the TX gearbox and its PRBS7 lane generators.
// Provides the pattern-mode enum, PRBS7 polynomial taps, the per-lane seed function and
// the width of the underflow statistics counter.
package txdata_pkg;

    typedef enum logic [1:0] {
        MODE_DATA  = 2'd0,
        MODE_PRBS7 = 2'd1,
        MODE_CLOCK = 2'd2,
        MODE_FIXED = 2'd3
    } txmode_t;

    // x^7 + x^6 + 1: feedback is state bit 6 xor state bit 5.
    localparam int PRBS7_LEN   = 7;
    localparam int PRBS7_TAP_A = 6;
    localparam int PRBS7_TAP_B = 5;

    localparam int UNDERFLOW_W = 16;

    // Distinct non-zero seed per lane so neighbouring lanes are decorrelated.
    function automatic logic [PRBS7_LEN-1:0] prbs7_seed(input int lane);
        prbs7_seed = PRBS7_LEN'((lane % 127) + 1);
    endfunction

endpackage

// File: rtl/prbs7_lane.sv
// prbs7_lane: one lane of PRBS7 (x^7+x^6+1), producing OUT_W new bits per clock, bit 0 first.
// Ports: clk, rst (sync, reloads seed), en (advance this cycle), seed, out (current chunk).
// Latency: out is combinational from the current state; state steps OUT_W bits when en=1.
module prbs7_lane
    import txdata_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [PRBS7_LEN-1:0] seed,
    output logic [OUT_W-1:0]     out
);

    logic [PRBS7_LEN-1:0] state_q;
    logic [PRBS7_LEN-1:0] state_d;
    logic                 fb;

    // Unroll OUT_W single-bit LFSR steps; each new feedback bit is also the output bit.
    always_comb begin
        state_d = state_q;
        out     = '0;
        fb      = 1'b0;
        for (int b = 0; b < OUT_W; b++) begin
            fb      = state_d[PRBS7_TAP_A] ^ state_d[PRBS7_TAP_B];
            state_d = {state_d[PRBS7_LEN-2:0], fb};
            out[b]  = fb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed;
        end else if (en) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/txdata_gearbox.sv
// txdata_gearbox: multi-lane TX gearbox, wide per-lane words -> OUT_W-bit chunks with pattern modes.
// Latency: a word held in the buffer at a slot boundary shows chunk 0 two edges later, chunk k at +k.
// Backpressure: in_ready = buffer empty, or last chunk of a DATA slot (buffer drains that edge).
// Ports: clk/rst (sync active-high); in_valid/in_ready/in_data word handshake; mode, lane_en,
//        fixed_pat, clr_stats controls; out_data/out_valid registered chunks; underflow_cnt stats.
module txdata_gearbox
    import txdata_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int SERDES_STAGES = 3,
    parameter int OUT_W         = 2**SERDES_STAGES,
    parameter int IN_W          = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [1:0]             mode,
    input  logic [LANES-1:0]       lane_en,
    input  logic [OUT_W-1:0]       fixed_pat,
    input  logic                   clr_stats,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_valid,
    output logic [UNDERFLOW_W-1:0] underflow_cnt
);

    localparam int RATIO  = IN_W / OUT_W;
    localparam int CIDX_W = $clog2(RATIO);
    localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(RATIO - 1);

    logic [CIDX_W-1:0]        cidx_q,      cidx_d;
    logic [LANES*IN_W-1:0]    buf_q,       buf_d;
    logic                     buf_full_q,  buf_full_d;
    logic [LANES*IN_W-1:0]    slot_q,      slot_d;
    logic                     slot_vld_q,  slot_vld_d;
    txmode_t                  mode_q,      mode_d;
    logic [LANES*OUT_W-1:0]   out_data_q,  out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic [UNDERFLOW_W-1:0]   uf_q,        uf_d;

    txmode_t                  mode_in;
    logic                     boundary;
    logic                     xfer;
    logic                     load_slot;
    logic                     underflow;
    logic [OUT_W-1:0]         clk_pat;
    logic [OUT_W-1:0]         lane_chunk;
    logic [LANES-1:0][OUT_W-1:0] prbs_out;

    // Per-lane PRBS generators; they only advance while the active slot is PRBS7.
    for (genvar g = 0; g < LANES; g++) begin : g_prbs
        prbs7_lane #(
            .OUT_W (OUT_W)
        ) u_prbs (
            .clk  (clk),
            .rst  (rst),
            .en   (mode_q == MODE_PRBS7),
            .seed (prbs7_seed(g)),
            .out  (prbs_out[g])
        );
    end

    assign mode_in  = txmode_t'(mode);
    assign boundary = (cidx_q == CIDX_LAST);

    // Readiness looks at the mode of the slot now ending, since the next mode is an input.
    // If mode leaves DATA exactly on a boundary while the buffer is full, an accepted word
    // replaces the buffered one.
    assign in_ready  = !buf_full_q || (boundary && mode_q == MODE_DATA);
    assign xfer      = in_valid && in_ready;
    assign load_slot = boundary && (mode_in == MODE_DATA) && buf_full_q;
    assign underflow = boundary && (mode_in == MODE_DATA) && !buf_full_q;

    // Control state: chunk counter, holding buffer, slot register, statistics.
    always_comb begin
        cidx_d     = boundary ? '0 : cidx_q + CIDX_W'(1);
        buf_d      = xfer ? in_data : buf_q;
        buf_full_d = buf_full_q;
        if (load_slot) buf_full_d = 1'b0;
        if (xfer)      buf_full_d = 1'b1;

        slot_d     = load_slot ? buf_q : slot_q;
        slot_vld_d = slot_vld_q;
        mode_d     = mode_q;
        if (boundary) begin
            mode_d     = mode_in;
            slot_vld_d = (mode_in != MODE_DATA) || buf_full_q;
        end

        uf_d = uf_q;
        if (underflow && uf_q != '1) uf_d = uf_q + UNDERFLOW_W'(1);
        if (clr_stats)               uf_d = '0;
    end

    // Chunk selection for the current cidx, registered into out_data next edge.
    always_comb begin
        clk_pat = '0;
        for (int b = 0; b < OUT_W; b++) begin
            clk_pat[b] = ((b % 2) == 0);
        end

        out_data_d = '0;
        lane_chunk = '0;
        for (int l = 0; l < LANES; l++) begin
            case (mode_q)
                MODE_DATA:  lane_chunk = slot_q[l*IN_W + int'(cidx_q)*OUT_W +: OUT_W];
                MODE_PRBS7: lane_chunk = prbs_out[l];
                MODE_CLOCK: lane_chunk = clk_pat;
                MODE_FIXED: lane_chunk = fixed_pat;
                default:    lane_chunk = '0;
            endcase
            // Idle slots and disabled lanes send zeros; consumption is unaffected.
            if (!slot_vld_q || !lane_en[l]) lane_chunk = '0;
            out_data_d[l*OUT_W +: OUT_W] = lane_chunk;
        end
        out_valid_d = slot_vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cidx_q      <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            slot_q      <= '0;
            slot_vld_q  <= 1'b0;
            mode_q      <= MODE_DATA;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            uf_q        <= '0;
        end else begin
            cidx_q      <= cidx_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            slot_q      <= slot_d;
            slot_vld_q  <= slot_vld_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            uf_q        <= uf_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_txdata_gearbox.sv
// tb_txdata_gearbox: randomized and directed stimulus for txdata_gearbox, checked every cycle
// against a slot-level reference model (word queue, PRBS bitstream tables) plus literal pins.
module tb_txdata_gearbox;

    localparam int LANES = 4;
    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int R     = IN_W / OUT_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic [1:0]             mode;
    logic [LANES-1:0]       lane_en;
    logic [OUT_W-1:0]       fixed_pat;
    logic                   clr_stats;
    logic [LANES*OUT_W-1:0] out_data;
    logic                   out_valid;
    logic [15:0]            underflow_cnt;

    always #5 clk = ~clk;

    txdata_gearbox #(
        .LANES         (LANES),
        .SERDES_STAGES (3),
        .IN_W          (IN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .mode          (mode),
        .lane_en       (lane_en),
        .fixed_pat     (fixed_pat),
        .clr_stats     (clr_stats),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .underflow_cnt (underflow_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // PRBS7 bitstream per lane, one full period, built bit by bit from the polynomial.
    bit prbs_seq [LANES][127];

    initial begin
        logic [6:0] s;
        logic       n;
        for (int l = 0; l < LANES; l++) begin
            s = 7'((l % 127) + 1);
            for (int k = 0; k < 127; k++) begin
                n = s[6] ^ s[5];
                s = {s[5:0], n};
                prbs_seq[l][k] = n;
            end
        end
    end

    function automatic logic [OUT_W-1:0] prbs_chunk(input int l, input int pos);
        logic [OUT_W-1:0] r;
        for (int b = 0; b < OUT_W; b++) r[b] = prbs_seq[l][(pos + b) % 127];
        return r;
    endfunction

    logic [LANES*IN_W-1:0]  m_pend[$];
    logic [LANES*IN_W-1:0]  m_slot;
    int                     m_t, m_mode, m_kind, m_uf;   // m_kind: 0 idle, 1 data, 2 pattern
    int                     m_pbit [LANES];
    logic                   m_live = 1'b0;
    logic                   m_xfer = 1'b0;
    logic [LANES*OUT_W-1:0] exp_data;
    logic                   exp_valid, exp_rdy;
    int                     p_tmp;
    logic                   rdy_tmp;
    logic [OUT_W-1:0]       ch_tmp;

    // Compare then advance the model by one edge, using the inputs present this cycle.
    always @(negedge clk) begin
        if (m_live && !rst) begin
            check("out_data", 64'(out_data), 64'(exp_data));
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            check("underflow_cnt", 64'(underflow_cnt), 64'(m_uf));
        end
        if (rst) begin
            m_live = 1'b1;
            m_t = 0; m_mode = 0; m_kind = 0; m_uf = 0;
            m_pend.delete();
            m_slot = '0;
            m_xfer = 1'b0;
            for (int l = 0; l < LANES; l++) m_pbit[l] = 0;
            exp_data = '0; exp_valid = 1'b0; exp_rdy = 1'b1;
        end else if (m_live) begin
            p_tmp   = m_t % R;
            rdy_tmp = (m_pend.size() == 0) || (p_tmp == R-1 && m_mode == 0);
            exp_valid = (m_kind != 0);
            for (int l = 0; l < LANES; l++) begin
                ch_tmp = '0;
                if (m_kind != 0) begin
                    case (m_mode)
                        0: ch_tmp = m_slot[l*IN_W + p_tmp*OUT_W +: OUT_W];
                        1: ch_tmp = prbs_chunk(l, m_pbit[l]);
                        2: for (int b = 0; b < OUT_W; b++) ch_tmp[b] = ((b % 2) == 0);
                        default: ch_tmp = fixed_pat;
                    endcase
                end
                if (!lane_en[l]) ch_tmp = '0;
                exp_data[l*OUT_W +: OUT_W] = ch_tmp;
            end
            if (m_mode == 1)
                for (int l = 0; l < LANES; l++) m_pbit[l] = (m_pbit[l] + OUT_W) % 127;
            if (p_tmp == R-1) begin
                m_mode = int'(mode);
                if (m_mode == 0) begin
                    if (m_pend.size() > 0) begin
                        m_slot = m_pend.pop_front();
                        m_kind = 1;
                    end else begin
                        m_kind = 0;
                        if (m_uf < 65535) m_uf++;
                    end
                end else begin
                    m_kind = 2;
                end
            end
            m_xfer = in_valid && rdy_tmp;
            if (m_xfer) begin
                if (m_pend.size() > 0) m_pend[0] = in_data;
                else                   m_pend.push_back(in_data);
            end
            if (clr_stats) m_uf = 0;
            m_t++;
            exp_rdy = (m_pend.size() == 0) || ((m_t % R) == R-1 && m_mode == 0);
        end
    end

    // ---------------- stimulus ----------------
    logic [LANES*IN_W-1:0]  last_acc, saved, w;
    logic [LANES*OUT_W-1:0] expw;
    logic                   found;
    int                     cnt;

    function automatic logic [LANES*IN_W-1:0] rand_word();
        logic [LANES*IN_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = $urandom;
        return r;
    endfunction

    // Move to the next cycle; offer a fresh word once the current one has been taken.
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_xfer) begin
            last_acc = in_data;
            in_data  = rand_word();
        end
    endtask

    task automatic wait_cidx(input int c);
        tick();
        for (int k = 0; k < R && (m_t % R) != c; k++) tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'd0;
        lane_en = 4'hF; fixed_pat = '0; clr_stats = 1'b0;
        last_acc = '0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_data", 64'(out_data), 64'h0);
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_in_ready", 64'(in_ready), 64'h1);
        check("reset_underflow", 64'(underflow_cnt), 64'h0);

        // Reset and idle: three idle DATA slots.
        for (int k = 0; k < 100 && m_t != 3*R; k++) tick();
        @(negedge clk);
        check("idle_underflow_3", 64'(underflow_cnt), 64'd3);
        check("idle_out_valid", 64'(out_valid), 64'h0);
        check("idle_out_data", 64'(out_data), 64'h0);
        tick(); clr_stats = 1'b1;
        tick(); clr_stats = 1'b0;
        @(negedge clk);
        check("clr_stats", 64'(underflow_cnt), 64'h0);

        // DATA streaming, first word lane 0 = 32'h04030201.
        wait_cidx(1);
        w = rand_word();
        w[31:0] = 32'h0403_0201;
        in_data = w; in_valid = 1'b1; clr_stats = 1'b1;
        tick(); clr_stats = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 4*R && !found; k++) begin
            @(negedge clk);
            if (out_valid && out_data[7:0] == 8'h01) found = 1'b1;
            else tick();
        end
        check("stream_first_chunk_seen", 64'(found), 64'h1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            @(negedge clk);
            check("stream_lane0_chunk", 64'(out_data[7:0]), 64'(k));
        end
        repeat (6*R) tick();
        @(negedge clk);
        check("stream_no_underflow", 64'(underflow_cnt), 64'h0);

        // Mode switch mid-slot to CLOCK, then back to DATA.
        wait_cidx(1);
        mode = 2'd2; in_valid = 1'b0;
        saved = last_acc;
        repeat (R) tick();
        @(negedge clk);
        check("clock_pattern", 64'(out_data), 64'h5555_5555);
        check("clock_valid", 64'(out_valid), 64'h1);
        wait_cidx(1);
        mode = 2'd0;
        repeat (R) tick();
        @(negedge clk);
        for (int l = 0; l < LANES; l++) expw[l*OUT_W +: OUT_W] = saved[l*IN_W +: OUT_W];
        check("buffered_word_after_clock", 64'(out_data), 64'(expw));
        tick(); in_valid = 1'b1;
        repeat (2*R) tick();

        // PRBS7 from the seeds: lane 0 seed 1 -> 8'h60, lane 1 seed 2 -> 8'h30.
        wait_cidx(1);
        mode = 2'd1; in_valid = 1'b0;
        repeat (R) tick();
        @(negedge clk);
        check("prbs_lane0_first", 64'(out_data[7:0]), 64'h60);
        check("prbs_lane1_first", 64'(out_data[15:8]), 64'h30);
        repeat (40*R) tick();

        // Lane gating in FIXED mode.
        wait_cidx(1);
        mode = 2'd3; fixed_pat = 8'hA5; lane_en = 4'b1010;
        repeat (R) tick();
        @(negedge clk);
        check("fixed_gated", 64'(out_data), 64'hA500_A500);
        check("fixed_valid", 64'(out_valid), 64'h1);

        // Randomized traffic, modes, gating and stats clears.
        lane_en = 4'hF;
        for (int k = 0; k < 400; k++) begin
            tick();
            in_valid  = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                lane_en   = 4'($urandom);
                fixed_pat = 8'($urandom);
            end
        end

        // Reset mid-word with a full buffer at cidx 2.
        tick();
        mode = 2'd0; in_valid = 1'b1; lane_en = 4'hF; clr_stats = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 12*R && !found; k++) begin
            tick();
            if ((m_t % R) == 2 && m_pend.size() == 1 && m_mode == 0) found = 1'b1;
        end
        check("midword_setup_reached", 64'(found), 64'h1);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_data", 64'(out_data), 64'h0);
        check("midrst_out_valid", 64'(out_valid), 64'h0);
        check("midrst_in_ready", 64'(in_ready), 64'h1);
        check("midrst_underflow", 64'(underflow_cnt), 64'h0);
        cnt = 0;
        for (int k = 0; k < 3*R; k++) begin
            tick();
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("midrst_word_discarded", 64'(cnt), 64'h0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
